spi_cfg_peripheral: RTL and testbench
=====================================

// Module: spi_cfg_peripheral
// PURPOSE
//  - SPI (mode 0) write-register peripheral; decodes 16-bit frames from an external controller.
//  - Holds the five 8-bit configuration registers that directly feed the PWM/output stage.
//  - Sits between the ui_in SPI pins and the PWM generator inside tt_um_uwasic_onboarding_miranda.
//  - SCLK is asynchronous to clk; the block samples all SPI pins on clk.
// PARAMETERS
//  SYNC_STAGES  2     flops per SPI input synchronizer (>=2)
//  NUM_REGS     5     implemented addresses 0..NUM_REGS-1
// PORTS
//  clk              in   1  system clock (>= 8x SCLK)
//  rst              in   1  synchronous active-high reset
//  sclk             in   1  SPI clock, idle low
//  ncs              in   1  SPI chip select, active low
//  copi             in   1  controller-out data, MSB first
//  cipo             out  1  controller-in data (READBACK_EN only, else tied 0)
//  en_reg_out_7_0   out  8  addr 0x00
//  en_reg_out_15_8  out  8  addr 0x01
//  en_reg_pwm_7_0   out  8  addr 0x02
//  en_reg_pwm_15_8  out  8  addr 0x03
//  pwm_duty_cycle   out  8  addr 0x04
//  cfg_update       out  1  one-clk pulse when any register is written
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): all registers, cipo, cfg_update = 0; shift reg, bit count cleared; FSM -> WAIT_IDLE.
//  - Sync: sclk/ncs/copi each pass SYNC_STAGES flops plus one history flop.
//    Edges are detected on the last two stages.
//  - Frame: bit15 = R/W (1 = write), bits14:8 = addr[6:0], bits7:0 = data; MSB first.
//    COPI is sampled on each synchronized SCLK rising edge.
//  - FSM states:
//    WAIT_IDLE: stay until sync ncs=1, then IDLE (a frame already in progress at reset is never captured).
//    IDLE: ncs falling -> SHIFT; clear bit count and shift reg.
//    SHIFT: each sclk rise shifts copi in; bit count (5b) saturates at 17; ncs rising -> COMMIT.
//    COMMIT: one clk, then -> IDLE.
//  - Commit rule: write only if count==16, R/W=1 and addr<NUM_REGS.
//    Register updates on the COMMIT clk; cfg_update=1 on that same clk.
//    Any other count, R/W=0, or invalid addr: frame discarded, no output change.
//  - Latency: register visible SYNC_STAGES+2 clks after the ncs pin rises.
//  - sclk edges while ncs is high are ignored. An sclk rise on the same clk as the ncs rise is dropped; ncs wins.
//  - Back-to-back frames are legal with ncs high for >= 2 clk.
//    An ncs fall during COMMIT is latched and SHIFT starts on the next clk.
//  - rst mid-frame: outputs clear immediately; the block waits for ncs high before accepting the next frame.
// CONFIGURATION
//  - Macro SPI_CFG_READBACK_EN.
//  - Defined:
//    After 8 bits with R/W=0 and a valid addr, the register value loads into a tx shift reg.
//    Its MSB is driven on cipo at the 8th sclk falling edge; one bit is shifted out per later falling edge.
//    Invalid addr reads return 0x00.
//    cipo=0 whenever ncs is high or during write frames.
//  - Undefined: no tx logic; cipo tied 0; reads discarded as above.
// TESTING
//  - Reset, then write 0x00<-0xFF -> en_reg_out_7_0=0xFF, other regs 0, exactly one cfg_update pulse.
//  - Write 0x04<-0x80, then 0x02<-0x01 -> pwm_duty_cycle=0x80, en_reg_pwm_7_0=0x01.
//  - Write to addr 0x05 and 0x7F -> all regs unchanged, no cfg_update.
//  - 15-bit frame, and 17-bit frame, writing 0x04<-0x55 -> pwm_duty_cycle unchanged.
//  - Assert rst after 8 bits of a write to 0x01, release mid-frame, finish the frame.
//    -> All regs 0 and no write. The next full write to 0x01<-0xA5 is accepted.
//  - With SPI_CFG_READBACK_EN: write 0x03<-0xC3, then read 0x03 -> cipo bits 9..16 = 1,1,0,0,0,0,1,1.
//    Without the macro, cipo stays 0.

Source files
------------

// File: rtl/spi_cfg_peripheral.sv
// SPI mode-0 write-register peripheral.
// Decodes 16-bit frames {rw, addr[6:0], data[7:0]} sent MSB first on copi.
// Five 8-bit configuration registers feed the PWM/output stage.
// All SPI pins are synchronized into clk; sclk must be at most clk/8.
// Optional feature: define SPI_CFG_READBACK_EN to shift register contents out on cipo
// during read frames. Without it, cipo is tied low.
module spi_cfg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update
);

  localparam logic [6:0] NumRegsW = 7'(NUM_REGS);

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StShift,
    StCommit
  } state_e;

  // Synchronizer chains: index 0 is the first flop, index SYNC_STAGES is the history flop.
  logic [SYNC_STAGES:0] sclk_sync;
  logic [SYNC_STAGES:0] ncs_sync;
  logic [SYNC_STAGES:0] copi_sync;

  logic sclk_rise;
  logic ncs_cur;
  logic ncs_rise;
  logic ncs_fall;
  logic copi_s;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        do_write;

  logic [7:0]  regs_q [NUM_REGS];
  logic        cfg_update_q;

  // Shift all SPI pins through their synchronizer chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-1:0], ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-1:0], copi};
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign ncs_cur   = ncs_sync[SYNC_STAGES-1];
  assign ncs_rise  = ncs_sync[SYNC_STAGES-1] & ~ncs_sync[SYNC_STAGES];
  assign ncs_fall  = ~ncs_sync[SYNC_STAGES-1] & ncs_sync[SYNC_STAGES];
  // copi taken from the history stage: it is the value held just before the sclk rise.
  assign copi_s    = copi_sync[SYNC_STAGES];

  // Frame FSM state, bit counter and receive shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitIdle;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; a write is committed only from the COMMIT state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    do_write = 1'b0;
    unique case (state_q)
      StWaitIdle: begin
        if (ncs_cur) state_d = StIdle;
      end
      StIdle: begin
        if (ncs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        // ncs rise wins over a coincident sclk rise.
        if (ncs_rise) begin
          state_d = StCommit;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
        end
      end
      StCommit: begin
        do_write = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] < NumRegsW);
        // A new frame that starts during COMMIT goes straight to SHIFT.
        if (ncs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  // Configuration registers and the one-clock update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= do_write;
      if (do_write) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign cfg_update      = cfg_update_q;

`ifdef SPI_CFG_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;
  logic [7:0] tx_q;
  logic       rd_q;
  logic       cipo_q;

  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
  // Address as it will stand once the 8th bit is shifted in.
  assign rd_addr   = {shift_q[5:0], copi_s};

  // Register file read mux; unimplemented addresses read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) rd_val = regs_q[i];
    end
  end

  // Transmit shifter: loaded on the 8th sclk rise of a read, emptied on falling edges.
  always_ff @(posedge clk) begin
    if (rst || (state_q != StShift)) begin
      tx_q   <= '0;
      rd_q   <= 1'b0;
      cipo_q <= 1'b0;
    end else if (sclk_rise && !ncs_rise && (cnt_q == 5'd7)) begin
      rd_q <= ~shift_q[6];
      tx_q <= shift_q[6] ? 8'h00 : rd_val;
    end else if (sclk_fall && rd_q && (cnt_q >= 5'd8)) begin
      cipo_q <= tx_q[7];
      tx_q   <= {tx_q[6:0], 1'b0};
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_peripheral.sv
// Scoreboard bench for spi_cfg_peripheral: the SPI controller task feeds a register-level
// model, which queues the expected register image for every accepted write; a monitor
// pops and compares it on each cfg_update pulse.
module tb_spi_cfg_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic       cipo;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_update;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int exp_pulses  = 0;

  logic [7:0]  exp_regs [5];
  logic [39:0] exp_q [$];

  spi_cfg_peripheral #(
    .SYNC_STAGES(2),
    .NUM_REGS   (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .ncs            (ncs),
    .copi           (copi),
    .cipo           (cipo),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .cfg_update     (cfg_update)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] dut_image();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_image();
    return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cfg_update pulse must match the oldest queued register image.
  always @(negedge clk) begin
    if (!rst && cfg_update) begin
      pulses++;
      check("cfg_update_expected", {39'b0, exp_q.size() != 0}, 40'd1);
      if (exp_q.size() != 0) check("regs_at_update", dut_image(), exp_q.pop_front());
    end
  end

  // One SPI bit: set copi, half period low, check cipo as the controller samples, rise.
  task automatic spi_bit(input logic b, input logic exp_cipo);
    copi = b;
    repeat (4) @(negedge clk);
    check("cipo_bit", {39'b0, cipo}, {39'b0, exp_cipo});
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Full frame of nbits taken from data[nbits-1:0], MSB first, then ncs high for gap clocks.
  task automatic spi_frame(input logic [31:0] data, input int nbits, input int gap,
                           input bit chk_lat);
    logic [7:0]  first8;
    logic [7:0]  rd_val;
    logic        valid;
    logic        exp_c;
    logic [39:0] old_img;
    for (int j = 0; j < 8; j++) first8[7-j] = data[nbits-1-j];
    valid  = (nbits == 16) && first8[7] && (first8[6:0] < 7'd5);
    rd_val = (first8[6:0] < 7'd5) ? exp_regs[first8[2:0]] : 8'h00;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= nbits; k++) begin
      exp_c = 1'b0;
`ifdef SPI_CFG_READBACK_EN
      if (!first8[7] && k >= 9 && k <= 16) exp_c = rd_val[16-k];
`endif
      spi_bit(data[nbits-k], exp_c);
    end
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    old_img = model_image();
    if (valid) begin
      exp_regs[first8[2:0]] = data[7:0];
      exp_q.push_back(model_image());
      exp_pulses++;
    end
    if (chk_lat) begin
      repeat (3) @(negedge clk);
      check("latency_old_value", dut_image(), old_img);
      @(negedge clk);
      check("latency_new_value", dut_image(), model_image());
      repeat (gap - 4) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic settle_check(input string name);
    repeat (8) @(negedge clk);
    check(name, dut_image(), model_image());
    check("no_pending_update", 40'(exp_q.size()), 40'd0);
  endtask

  function automatic logic [15:0] wr(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    logic        rw;
    logic [6:0]  a;
    int          nb;
    int          gap;

    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_regs", dut_image(), 40'h0);
    check("reset_cfg_update", {39'b0, cfg_update}, 40'd0);
    check("reset_cipo", {39'b0, cipo}, 40'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // First write, with exact latency check.
    spi_frame({16'h0, wr(7'h00, 8'hFF)}, 16, 10, 1'b1);
    settle_check("write_addr0");
    check("single_pulse", 40'(pulses), 40'd1);

    spi_frame({16'h0, wr(7'h04, 8'h80)}, 16, 10, 1'b0);
    spi_frame({16'h0, wr(7'h02, 8'h01)}, 16, 10, 1'b0);
    settle_check("write_pwm_regs");

    // Invalid addresses.
    spi_frame({16'h0, wr(7'h05, 8'h12)}, 16, 10, 1'b0);
    spi_frame({16'h0, wr(7'h7F, 8'h34)}, 16, 10, 1'b0);
    settle_check("invalid_addr");

    // Short and long frames.
    spi_frame({17'h0, wr(7'h04, 8'h55) >> 1}, 15, 10, 1'b0);
    spi_frame({15'h0, wr(7'h04, 8'h55), 1'b0}, 17, 10, 1'b0);
    settle_check("bad_length");

    // Back-to-back with minimal gap, and a one-clock gap landing in COMMIT.
    spi_frame({16'h0, wr(7'h01, 8'h3C)}, 16, 2, 1'b0);
    spi_frame({16'h0, wr(7'h03, 8'h5A)}, 16, 1, 1'b0);
    spi_frame({16'h0, wr(7'h00, 8'h96)}, 16, 10, 1'b0);
    settle_check("back_to_back");

    // Reset in the middle of a write to 0x01.
    f = wr(7'h01, 8'h77);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 15; k >= 8; k--) spi_bit(f[k], 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 7; k >= 0; k--) spi_bit(f[k], 1'b0);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    settle_check("reset_mid_frame");
    spi_frame({16'h0, wr(7'h01, 8'hA5)}, 16, 10, 1'b0);
    settle_check("write_after_reset");

    // Readback of a written register (cipo expectation depends on the build).
    spi_frame({16'h0, wr(7'h03, 8'hC3)}, 16, 10, 1'b0);
    spi_frame({16'h0, 1'b0, 7'h03, 8'h00}, 16, 10, 1'b0);
    settle_check("read_no_write");

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      rw  = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
      f   = {rw, a, 8'($urandom)};
      nb  = $urandom_range(0, 5);
      nb  = (nb == 0) ? 15 : (nb == 1) ? 17 : 16;
      gap = $urandom_range(2, 10);
      if (nb == 15) spi_frame({17'h0, f[15:1]}, 15, gap, 1'b0);
      else if (nb == 17) spi_frame({15'h0, f, 1'($urandom)}, 17, gap, 1'b0);
      else spi_frame({16'h0, f}, 16, gap, 1'b0);
      if (gap >= 8) check("random_regs", dut_image(), model_image());
    end
    settle_check("random_final");
    check("pulse_count", 40'(pulses), 40'(exp_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
